// File: rtl/ctx_state_access_port_pkg.sv
// Shared types and helpers for the context-access port.
package ctx_access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_STREAM,
        WR_COLLECT,
        COMMIT
    } ctx_state_t;

    function automatic int nchunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/ctx_state_access_port_if.sv
// Host/owner signal bundle of the context-access port; slave side is the port itself.
interface ctx_state_access_port_if #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 32
);
    logic [WIDTH-1:0] state_in;
    logic [WIDTH-1:0] xmask_in;
    logic             rd_start;
    logic             rd_valid;
    logic             rd_ready;
    logic [CHUNK-1:0] rd_data;
    logic             rd_last;
    logic             wr_valid;
    logic             wr_ready;
    logic [CHUNK-1:0] wr_data;
    logic [WIDTH-1:0] state_out;
    logic             state_load;
    logic             busy;

    modport slave (
        input  state_in, xmask_in, rd_start, rd_ready, wr_valid, wr_data,
        output rd_valid, rd_data, rd_last, wr_ready, state_out, state_load, busy
    );

    modport master (
        output state_in, xmask_in, rd_start, rd_ready, wr_valid, wr_data,
        input  rd_valid, rd_data, rd_last, wr_ready, state_out, state_load, busy
    );
endinterface

// File: rtl/ctx_state_access_port_chunk_mux.sv
// Selects one CHUNK-wide beat out of a chunk-aligned vector, chunk 0 at the LSBs.
module ctx_chunk_mux #(
    parameter int IN_W  = 64,
    parameter int CHUNK = 32,
    parameter int SEL_W = 2
) (
    input  logic [IN_W-1:0]  i_vec,
    input  logic [SEL_W-1:0] i_sel,
    output logic [CHUNK-1:0] o_chunk
);
    localparam int N = IN_W / CHUNK;

    logic [CHUNK-1:0] w_chunks [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_split
        assign w_chunks[gi] = i_vec[gi*CHUNK +: CHUNK];
    end

    always_comb begin
        o_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_chunk = w_chunks[k];
            end
        end
    end
endmodule

// File: rtl/ctx_state_access_port.sv
// Context-access port: snapshots live state and streams it out in beats, and collects a
// {data, wen} write-back payload that is committed only when the wen toggle vector changes.
module ctx_state_access_port
    import ctx_access_pkg::*;
#(
    parameter int WIDTH      = 1024,
    parameter int N_WEN      = 1,
    parameter int FOUR_STATE = 0,
    parameter int CHUNK      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ctx_state_access_port_if.slave bus
);
    localparam int NRCH    = nchunks(WIDTH, CHUNK);
    localparam int NRBEATS = (FOUR_STATE != 0) ? 2 * NRCH : NRCH;
    localparam int NWCH    = nchunks(WIDTH + N_WEN, CHUNK);
    localparam int PADW    = NRCH * CHUNK;
    localparam int PLANE_W = NRBEATS * CHUNK;
    localparam int PLW     = WIDTH + N_WEN;
    localparam int PW      = NWCH * CHUNK;
    localparam int MAXB    = (NRBEATS > NWCH) ? NRBEATS : NWCH;
    localparam int CNT_W   = $clog2(MAXB) + 1;

    ctx_state_t       r_state;
    logic [WIDTH-1:0] r_snap;
    logic [WIDTH-1:0] r_xsnap;
    logic [WIDTH-1:0] r_state_out;
    logic [PW-1:0]    r_payload;
    logic [N_WEN-1:0] r_wen_prev;
    logic [CNT_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_wr_idx;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic             r_state_load;

    logic [PLANE_W-1:0] w_plane;
    logic [N_WEN-1:0]   w_wen;
    logic [WIDTH-1:0]   w_data;
    logic               w_wr_ready;
    logic               w_wr_fire;

    // Each plane is zero-padded to a whole number of beats; the xmask plane follows the data plane.
    if (FOUR_STATE != 0) begin : g_four
        assign w_plane = {PADW'(r_xsnap), PADW'(r_snap)};
    end else begin : g_two
        logic w_unused_xsnap;
        assign w_plane        = PADW'(r_snap);
        assign w_unused_xsnap = ^r_xsnap;
    end

    if (PW > PLW) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^r_payload[PW-1:PLW];
    end

    ctx_chunk_mux #(
        .IN_W  (PLANE_W),
        .CHUNK (CHUNK),
        .SEL_W (CNT_W)
    ) u_rd_mux (
        .i_vec   (w_plane),
        .i_sel   (r_rd_idx),
        .o_chunk (bus.rd_data)
    );

    assign w_wen      = r_payload[N_WEN-1:0];
    assign w_data     = r_payload[N_WEN +: WIDTH];
    assign w_wr_ready = ((r_state == IDLE) && !bus.rd_start) || (r_state == WR_COLLECT);
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_snap       <= '0;
            r_xsnap      <= '0;
            r_state_out  <= '0;
            r_payload    <= '0;
            r_wen_prev   <= '0;
            r_rd_idx     <= '0;
            r_wr_idx     <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_state_load <= 1'b0;
        end else begin
            r_state_load <= 1'b0;
            for (int k = 0; k < NWCH; k++) begin
                if (w_wr_fire && (r_wr_idx == CNT_W'(k))) begin
                    r_payload[k*CHUNK +: CHUNK] <= bus.wr_data;
                end
            end
            case (r_state)
                IDLE: begin
                    if (bus.rd_start) begin
                        r_snap     <= bus.state_in;
                        r_xsnap    <= bus.xmask_in;
                        r_rd_idx   <= '0;
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (NRBEATS == 1);
                        r_state    <= RD_STREAM;
                    end else if (bus.wr_valid) begin
                        r_wr_idx <= CNT_W'(1);
                        r_state  <= (NWCH == 1) ? COMMIT : WR_COLLECT;
                    end
                end
                RD_STREAM: begin
                    if (bus.rd_ready) begin
                        if (r_rd_last) begin
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_rd_idx   <= '0;
                            r_state    <= IDLE;
                        end else begin
                            r_rd_idx  <= r_rd_idx + 1'b1;
                            r_rd_last <= (r_rd_idx == CNT_W'(NRBEATS - 2));
                        end
                    end
                end
                WR_COLLECT: begin
                    if (bus.wr_valid) begin
                        if (r_wr_idx == CNT_W'(NWCH - 1)) begin
                            r_wr_idx <= '0;
                            r_state  <= COMMIT;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // An unchanged wen vector means the host re-sent an already committed payload.
                    if (w_wen != r_wen_prev) begin
                        r_state_out  <= w_data;
                        r_state_load <= 1'b1;
                        r_wen_prev   <= w_wen;
                    end
                    r_wr_idx <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_last    = r_rd_last;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.state_out  = r_state_out;
    assign bus.state_load = r_state_load;
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_ctx_state_access_port.sv
// Bench for ctx_state_access_port: a 64-bit two-state port and a 40-bit four-state port
// (N_WEN=2), driven through shared stimulus and checked against a behavioural model.
module tb_ctx_state_access_port;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic [63:0] state_in;
    logic [63:0] xmask_in;
    logic        rd_start;
    logic        rd_ready;
    logic        wr_valid;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_out      [2];
    logic [1:0]  m_wen_prev [2];
    logic [31:0] seen       [8];

    ctx_state_access_port_if #(.WIDTH(64), .CHUNK(32)) if0 ();
    ctx_state_access_port_if #(.WIDTH(40), .CHUNK(32)) if1 ();

    ctx_state_access_port #(.WIDTH(64), .N_WEN(1), .FOUR_STATE(0), .CHUNK(32)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    ctx_state_access_port #(.WIDTH(40), .N_WEN(2), .FOUR_STATE(1), .CHUNK(32)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    assign if0.state_in = state_in;
    assign if0.xmask_in = xmask_in;
    assign if0.rd_start = rd_start && (sel == 1'b0);
    assign if0.rd_ready = rd_ready;
    assign if0.wr_valid = wr_valid && (sel == 1'b0);
    assign if0.wr_data  = wr_data;
    assign if1.state_in = state_in[39:0];
    assign if1.xmask_in = xmask_in[39:0];
    assign if1.rd_start = rd_start && (sel == 1'b1);
    assign if1.rd_ready = rd_ready;
    assign if1.wr_valid = wr_valid && (sel == 1'b1);
    assign if1.wr_data  = wr_data;

    logic        o_rd_valid, o_rd_last, o_wr_ready, o_state_load, o_busy;
    logic [31:0] o_rd_data;
    logic [63:0] o_state_out;
    assign o_rd_valid   = sel ? if1.rd_valid   : if0.rd_valid;
    assign o_rd_last    = sel ? if1.rd_last    : if0.rd_last;
    assign o_wr_ready   = sel ? if1.wr_ready   : if0.wr_ready;
    assign o_state_load = sel ? if1.state_load : if0.state_load;
    assign o_busy       = sel ? if1.busy       : if0.busy;
    assign o_rd_data    = sel ? if1.rd_data    : if0.rd_data;
    assign o_state_out  = sel ? {24'h0, if1.state_out} : if0.state_out;

    function automatic int f_width(input logic s);
        return s ? 40 : 64;
    endfunction

    function automatic int f_nwen(input logic s);
        return s ? 2 : 1;
    endfunction

    function automatic int f_rbeats(input logic s);
        int nr = (f_width(s) + 31) / 32;
        return s ? 2 * nr : nr;
    endfunction

    function automatic int f_wbeats(input logic s);
        return (f_width(s) + f_nwen(s) + 31) / 32;
    endfunction

    function automatic logic [127:0] f_mask(input int n);
        return (128'd1 << n) - 128'd1;
    endfunction

    // Beat k of the read stream: data plane first, then xmask plane, each truncated to the port width.
    function automatic logic [31:0] f_read_beat(input logic s, input logic [63:0] snap,
                                                input logic [63:0] xm, input int k);
        int           nr    = (f_width(s) + 31) / 32;
        logic [127:0] plane = (k < nr) ? {64'h0, snap} : {64'h0, xm};
        plane = plane & f_mask(f_width(s));
        return 32'(plane >> (32 * (k % nr)));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [63:0] s, input logic [63:0] xm, input int stall,
                           input bit collide);
        int nb = f_rbeats(sel);
        state_in = s;
        xmask_in = xm;
        rd_start = 1'b1;
        rd_ready = 1'b0;
        if (collide) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
        end
        #1;
        chk("rd_start_wr_ready", o_wr_ready, 0);
        @(negedge clk);
        rd_start = 1'b0;
        wr_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int t = 0; t < stall; t++) begin
                rd_ready = 1'b0;
                state_in = {$urandom, $urandom};
                xmask_in = {$urandom, $urandom};
                @(negedge clk);
                chk("rd_stall_valid", o_rd_valid, 1);
                chk("rd_stall_data", o_rd_data, f_read_beat(sel, s, xm, k));
            end
            chk("rd_valid", o_rd_valid, 1);
            chk("rd_data", o_rd_data, f_read_beat(sel, s, xm, k));
            chk("rd_last", o_rd_last, (k == nb - 1));
            chk("rd_stream_wr_ready", o_wr_ready, 0);
            seen[k]  = o_rd_data;
            rd_ready = 1'b1;
            state_in = {$urandom, $urandom};
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("rd_done_busy", o_busy, 0);
        chk("rd_done_valid", o_rd_valid, 0);
        $display("read  dut%0d snap=%h xm=%h stall=%0d collide=%0d", sel, s, xm, stall, collide);
    endtask

    task automatic do_write(input logic [127:0] pl, input int gap);
        int          nb = f_wbeats(sel);
        logic [1:0]  wen;
        logic [63:0] data;
        logic        exp_load;
        for (int j = 0; j < nb; j++) begin
            if (j > 0) begin
                for (int t = 0; t < gap; t++) begin
                    wr_valid = 1'b0;
                    @(negedge clk);
                    chk("wr_gap_busy", o_busy, 1);
                end
            end
            wr_valid = 1'b1;
            wr_data  = 32'(pl >> (32 * j));
            #1;
            chk("wr_ready", o_wr_ready, 1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("commit_busy", o_busy, 1);
        chk("commit_no_early_load", o_state_load, 0);
        wen      = 2'(pl & f_mask(f_nwen(sel)));
        data     = 64'((pl >> f_nwen(sel)) & f_mask(f_width(sel)));
        exp_load = (wen != m_wen_prev[sel]);
        if (exp_load) begin
            m_out[sel]      = data;
            m_wen_prev[sel] = wen;
        end
        @(negedge clk);
        chk("state_load", o_state_load, exp_load);
        chk("state_out", o_state_out, m_out[sel]);
        chk("wr_done_busy", o_busy, 0);
        @(negedge clk);
        chk("state_load_one_cycle", o_state_load, 0);
        $display("write dut%0d payload=%h gap=%0d load=%0d", sel, pl, gap, exp_load);
    endtask

    initial begin
        logic [127:0] pl;
        sel      = 1'b0;
        state_in = '0;
        xmask_in = '0;
        rd_start = 1'b0;
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        for (int d = 0; d < 2; d++) begin
            m_out[d]      = '0;
            m_wen_prev[d] = '0;
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            chk("rst_rd_valid", o_rd_valid, 0);
            chk("rst_rd_last", o_rd_last, 0);
            chk("rst_state_load", o_state_load, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_rd_data", o_rd_data, 0);
            chk("rst_state_out", o_state_out, 0);
            chk("rst_wr_ready", o_wr_ready, 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 1'b0;
        @(negedge clk);

        do_read(64'h1122334455667788, 64'h0, 0, 1'b0);
        chk("read_beat0", seen[0], 32'h55667788);
        chk("read_beat1", seen[1], 32'h11223344);
        do_read(64'h1122334455667788, 64'h0, 3, 1'b0);
        chk("stall_beat0", seen[0], 32'h55667788);
        chk("stall_beat1", seen[1], 32'h11223344);

        pl = {32'h0, 32'h0, 32'h0000000A, 32'h00000001};
        do_write(pl, 0);
        chk("write_state_out", o_state_out, 64'h0000000500000000);
        do_write(pl, 1);
        do_write({32'h0, 32'h0, 32'h0000000A, 32'h00000000}, 0);

        sel = 1'b1;
        do_read({$urandom, $urandom}, 64'hFF, 1, 1'b0);
        chk("xmask_beat2", seen[2], 32'h000000FF);
        chk("xmask_beat3", seen[3], 32'h0);

        sel = 1'b0;
        do_read({$urandom, $urandom}, 64'h0, 0, 1'b1);

        // Abort a write after one of its three beats.
        wr_valid = 1'b1;
        wr_data  = 32'h00000003;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("midwr_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midwr_rst_busy", o_busy, 0);
        chk("midwr_rst_load", o_state_load, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_out[d]      = '0;
            m_wen_prev[d] = '0;
        end
        chk("midwr_state_out", o_state_out, 0);
        @(negedge clk);
        chk("midwr_after_busy", o_busy, 0);
        chk("midwr_after_load", o_state_load, 0);
        do_write({32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0}, 0);
        do_write({32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF1}, 0);

        for (int it = 0; it < 60; it++) begin
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                do_read({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2),
                        ($urandom_range(0, 3) == 0));
            end else begin
                pl = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 0) begin
                    pl = (pl & ~f_mask(f_nwen(sel))) | {126'h0, m_wen_prev[sel]};
                end
                do_write(pl, $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
